// File: rtl/lbist_misr_if.sv
// Request/CUT/response channel bundle between lbist_controller and one lbist_misr.
// The controller side drives requests and CUT words; the MISR side answers with a signature.
interface lbist_misr_if #(
  parameter int CUT_BITS       = 32,
  parameter int SIGNATURE_BITS = 32,
  parameter int MISR_MSG_BITS  = 5
);
  logic                      misr_req_val;
  logic [MISR_MSG_BITS:0]    misr_req_msg;
  logic                      misr_req_rdy;
  logic                      cut_out_val;
  logic [CUT_BITS-1:0]       cut_out_msg;
  logic                      cut_out_rdy;
  logic                      misr_resp_val;
  logic [SIGNATURE_BITS-1:0] misr_resp_msg;
  logic                      misr_resp_rdy;

  modport master (
    output misr_req_val, misr_req_msg, cut_out_val, cut_out_msg, misr_resp_rdy,
    input  misr_req_rdy, cut_out_rdy, misr_resp_val, misr_resp_msg
  );

  modport slave (
    input  misr_req_val, misr_req_msg, cut_out_val, cut_out_msg, misr_resp_rdy,
    output misr_req_rdy, cut_out_rdy, misr_resp_val, misr_resp_msg
  );
endinterface

// File: rtl/lbist_misr.sv
// Multiple-input signature register: hashes a requested number of CUT words
// into a signature and returns it. Moore IDLE/HASH/DONE controller.
module lbist_misr #(
  parameter int                        CUT_BITS            = 32,
  parameter int                        SIGNATURE_BITS      = 32,
  parameter int                        MAX_OUTPUTS_TO_HASH = 32,
  parameter int                        MISR_MSG_BITS       = $clog2(MAX_OUTPUTS_TO_HASH),
  parameter logic [SIGNATURE_BITS-1:0] POLY                = 32'h04C11DB7
) (
  input  logic        clk,
  input  logic        reset,
  lbist_misr_if.slave bus
);

  localparam int                 MSG_W   = MISR_MSG_BITS + 1;
  localparam logic [MSG_W-1:0]   MAX_CNT = MSG_W'(MAX_OUTPUTS_TO_HASH);

  typedef enum logic [1:0] {IDLE, HASH, DONE} state_t;

  state_t                    state, state_next;
  logic [MSG_W-1:0]          target;
  logic [MSG_W-1:0]          count;
  logic [MSG_W-1:0]          count_inc;
  logic [MSG_W-1:0]          req_sat;
  logic [SIGNATURE_BITS-1:0] sig;
  logic [SIGNATURE_BITS-1:0] sig_next;
  logic                      req_fire;
  logic                      cut_fire;
  logic                      resp_fire;

  // Handshake outputs decode from the state register only, so no input reaches an output.
  assign bus.misr_req_rdy  = (state == IDLE);
  assign bus.cut_out_rdy   = (state == HASH);
  assign bus.misr_resp_val = (state == DONE);
  assign bus.misr_resp_msg = sig;

  assign req_fire  = bus.misr_req_val  && bus.misr_req_rdy;
  assign cut_fire  = bus.cut_out_val   && bus.cut_out_rdy;
  assign resp_fire = bus.misr_resp_val && bus.misr_resp_rdy;

  assign req_sat   = (bus.misr_req_msg > MAX_CNT) ? MAX_CNT : bus.misr_req_msg;
  assign count_inc = count + MSG_W'(1);

  // Galois-style shift with polynomial feedback, CUT word folded into the low bits.
  assign sig_next = {sig[SIGNATURE_BITS-2:0], 1'b0}
                  ^ (sig[SIGNATURE_BITS-1] ? POLY : '0)
                  ^ SIGNATURE_BITS'(bus.cut_out_msg);

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order the always blocks are evaluated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (req_fire)                        state_next = (req_sat == '0) ? DONE : HASH;
      HASH: if (cut_fire && count_inc == target) state_next = DONE;
      DONE: if (resp_fire)                       state_next = IDLE;
      default:                                   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig    <= '0;
      count  <= '0;
      target <= '0;
    end else begin
      unique case (state)
        IDLE: if (req_fire) begin
          target <= req_sat;
          count  <= '0;
          sig    <= '0;
        end
        HASH: if (cut_fire) begin
          sig   <= sig_next;
          count <= count_inc;
        end
        default: ;  // DONE holds the signature until the next accepted request
      endcase
    end
  end

endmodule

// File: tb/tb_lbist_misr.sv
// Directed self-checking bench for lbist_misr with 8-bit CUT/signature, POLY=8'h1D, MAX=32.
module tb_lbist_misr;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  lbist_misr_if #(.CUT_BITS(8), .SIGNATURE_BITS(8), .MISR_MSG_BITS(5)) bus ();

  lbist_misr #(
    .CUT_BITS            (8),
    .SIGNATURE_BITS      (8),
    .MAX_OUTPUTS_TO_HASH (32),
    .MISR_MSG_BITS       (5),
    .POLY                (8'h1D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [5:0] n);
    bus.misr_req_val = 1'b1;
    bus.misr_req_msg = n;
    tick();
    bus.misr_req_val = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    bus.cut_out_val = 1'b1;
    bus.cut_out_msg = w;
    tick();
    bus.cut_out_val = 1'b0;
  endtask

  task automatic take_resp();
    bus.misr_resp_rdy = 1'b1;
    tick();
    bus.misr_resp_rdy = 1'b0;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_req_rdy"},  32'(bus.misr_req_rdy),  32'd1);
    check({tag, "_cut_rdy"},  32'(bus.cut_out_rdy),   32'd0);
    check({tag, "_resp_val"}, 32'(bus.misr_resp_val), 32'd0);
    check({tag, "_resp_msg"}, 32'(bus.misr_resp_msg), 32'h00);
  endtask

  logic [7:0] seq3 [3]     = '{8'h01, 8'h02, 8'h03};
  logic [7:0] seq3_sig [3] = '{8'h01, 8'h00, 8'h03};
  logic [7:0] bp_words [4] = '{8'h80, 8'h40, 8'h20, 8'h10};

  initial begin
    int n_hs;
    int idx;
    logic v;

    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.misr_req_val  = 1'b0;
    bus.misr_req_msg  = '0;
    bus.cut_out_val   = 1'b0;
    bus.cut_out_msg   = '0;
    bus.misr_resp_rdy = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state and CUT words ignored in IDLE
    check_idle_reset("rst");
    bus.cut_out_val = 1'b1;
    bus.cut_out_msg = 8'hAA;
    for (int i = 0; i < 3; i++) tick();
    bus.cut_out_val = 1'b0;
    check("idle_words_sig", 32'(bus.misr_resp_msg), 32'h00);
    check("idle_words_req_rdy", 32'(bus.misr_req_rdy), 32'd1);

    // Count 3, back-to-back words; a competing request during HASH is ignored
    send_req(6'd3);
    check("c3_cut_rdy", 32'(bus.cut_out_rdy), 32'd1);
    check("c3_req_rdy", 32'(bus.misr_req_rdy), 32'd0);
    bus.misr_req_val = 1'b1;
    bus.misr_req_msg = 6'd5;
    for (int i = 0; i < 3; i++) begin
      check("c3_pre_val", 32'(bus.misr_resp_val), 32'd0);
      send_word(seq3[i]);
      check($sformatf("c3_sig%0d", i), 32'(bus.misr_resp_msg), 32'(seq3_sig[i]));
    end
    bus.misr_req_val = 1'b0;
    check("c3_resp_val", 32'(bus.misr_resp_val), 32'd1);
    check("c3_cut_rdy_done", 32'(bus.cut_out_rdy), 32'd0);
    take_resp();
    check("c3_back_idle", 32'(bus.misr_req_rdy), 32'd1);
    check("c3_resp_val_low", 32'(bus.misr_resp_val), 32'd0);
    bus.cut_out_val = 1'b1;
    bus.cut_out_msg = 8'hFF;
    tick();
    tick();
    bus.cut_out_val = 1'b0;
    check("c3_sig_retained", 32'(bus.misr_resp_msg), 32'h03);

    // Feedback: 0x80 then 0x00 shifts the MSB out through POLY
    send_req(6'd2);
    send_word(8'h80);
    send_word(8'h00);
    check("fb_resp_val", 32'(bus.misr_resp_val), 32'd1);
    check("fb_sig", 32'(bus.misr_resp_msg), 32'h1D);
    take_resp();

    // Zero request goes straight to DONE with a cleared signature
    send_req(6'd0);
    check("zero_cut_rdy", 32'(bus.cut_out_rdy), 32'd0);
    check("zero_resp_val", 32'(bus.misr_resp_val), 32'd1);
    check("zero_sig", 32'(bus.misr_resp_msg), 32'h00);
    take_resp();

    // Saturation: 40 requested, 32 honoured
    send_req(6'd40);
    n_hs = 0;
    for (int c = 0; c < 100 && !bus.misr_resp_val; c++) begin
      bus.cut_out_val = 1'b1;
      bus.cut_out_msg = 8'h01;
      if (bus.cut_out_rdy) n_hs++;
      tick();
    end
    bus.cut_out_val = 1'b0;
    check("sat_resp_val", 32'(bus.misr_resp_val), 32'd1);
    check("sat_words", 32'(n_hs), 32'd32);
    take_resp();

    // Random CUT backpressure: only handshaken words are hashed (expected 0x39)
    send_req(6'd4);
    idx = 0;
    for (int c = 0; c < 200 && !bus.misr_resp_val; c++) begin
      v = 1'($urandom_range(0, 1));
      bus.cut_out_val = v;
      bus.cut_out_msg = v ? bp_words[idx] : 8'hFF;
      tick();
      if (v) idx++;
    end
    bus.cut_out_val = 1'b0;
    check("bp_resp_val", 32'(bus.misr_resp_val), 32'd1);
    check("bp_words", 32'(idx), 32'd4);
    check("bp_sig", 32'(bus.misr_resp_msg), 32'h39);

    // Response backpressure: held stable for 10 cycles despite other traffic
    bus.cut_out_val  = 1'b1;
    bus.cut_out_msg  = 8'h77;
    bus.misr_req_val = 1'b1;
    bus.misr_req_msg = 6'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_val", 32'(bus.misr_resp_val), 32'd1);
      check("hold_sig", 32'(bus.misr_resp_msg), 32'h39);
    end
    bus.cut_out_val  = 1'b0;
    bus.misr_req_val = 1'b0;
    take_resp();
    check("hold_release_req_rdy", 32'(bus.misr_req_rdy), 32'd1);
    check("hold_release_val", 32'(bus.misr_resp_val), 32'd0);

    // Asynchronous reset in the middle of HASH
    send_req(6'd4);
    send_word(8'h11);
    send_word(8'h23);
    check("midrst_partial_sig", 32'(bus.misr_resp_msg), 32'h01);
    #2;
    reset = 1'b1;
    #1;
    check_idle_reset("midrst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    send_req(6'd1);
    send_word(8'h5A);
    check("post_rst_val", 32'(bus.misr_resp_val), 32'd1);
    check("post_rst_sig", 32'(bus.misr_resp_msg), 32'h5A);
    take_resp();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
